// File: rtl/level_pkg.sv
// Shared level-1 definitions: hazard monitor FSM states and the geometry/timing
// defaults that the renderer and the level state machine also use.
package level_pkg;

  typedef enum logic [1:0] {
    ALIVE   = 2'd0,
    CONFIRM = 2'd1,
    DYING   = 2'd2,
    REQUEST = 2'd3
  } hazard_state_t;

  localparam int unsigned PIT1_X_MIN_DEF       = 32'd200;
  localparam int unsigned PIT1_X_MAX_DEF       = 32'd239;
  localparam int unsigned PIT2_X_MIN_DEF       = 32'd360;
  localparam int unsigned PIT2_X_MAX_DEF       = 32'd399;
  localparam int unsigned SPIKE_X_MIN_DEF      = 32'd480;
  localparam int unsigned SPIKE_X_MAX_DEF      = 32'd543;
  localparam int unsigned FLOOR_Y_DEF          = 32'd400;
  localparam int unsigned PIT_LETHAL_FRAME_DEF = 32'd3;

endpackage

// File: rtl/hazard_decode.sv
// Combinational hazard detector: which hazards are live for the current level
// phase, and whether the player is standing inside one of them.
module hazard_decode
  import level_pkg::*;
#(
  parameter int unsigned PIT1_X_MIN       = PIT1_X_MIN_DEF,
  parameter int unsigned PIT1_X_MAX       = PIT1_X_MAX_DEF,
  parameter int unsigned PIT2_X_MIN       = PIT2_X_MIN_DEF,
  parameter int unsigned PIT2_X_MAX       = PIT2_X_MAX_DEF,
  parameter int unsigned SPIKE_X_MIN      = SPIKE_X_MIN_DEF,
  parameter int unsigned SPIKE_X_MAX      = SPIKE_X_MAX_DEF,
  parameter int unsigned FLOOR_Y          = FLOOR_Y_DEF,
  parameter int unsigned PIT_LETHAL_FRAME = PIT_LETHAL_FRAME_DEF
) (
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       pit_opening_1,
  input  logic       pit_opened_1,
  input  logic       pit_opening_2,
  input  logic       pit_opened_2,
  input  logic       spikes,
  input  logic       spikes_opened,
  input  logic [6:0] animation_frame_num,
  output logic       hazard
);

  localparam logic [9:0] P1_MIN = 10'(PIT1_X_MIN);
  localparam logic [9:0] P1_MAX = 10'(PIT1_X_MAX);
  localparam logic [9:0] P2_MIN = 10'(PIT2_X_MIN);
  localparam logic [9:0] P2_MAX = 10'(PIT2_X_MAX);
  localparam logic [9:0] SP_MIN = 10'(SPIKE_X_MIN);
  localparam logic [9:0] SP_MAX = 10'(SPIKE_X_MAX);
  localparam logic [9:0] FLOOR  = 10'(FLOOR_Y);
  localparam logic [6:0] LETHAL = 7'(PIT_LETHAL_FRAME);

  logic floor_s;
  logic lethal_frame_s;
  logic pit1_live_s;
  logic pit2_live_s;
  logic spike_live_s;
  logic in_pit1_s;
  logic in_pit2_s;
  logic in_spike_s;

  assign floor_s        = (y_pos >= FLOOR);
  assign lethal_frame_s = (animation_frame_num >= LETHAL);

  // A pit stays live through every later phase of the level, not just its own.
  assign pit1_live_s  = pit_opened_1 | pit_opening_2 | pit_opened_2 | spikes | spikes_opened
                      | (pit_opening_1 & lethal_frame_s);
  assign pit2_live_s  = pit_opened_2 | spikes | spikes_opened
                      | (pit_opening_2 & lethal_frame_s);
  assign spike_live_s = spikes_opened;

  assign in_pit1_s  = (x_pos >= P1_MIN) && (x_pos <= P1_MAX);
  assign in_pit2_s  = (x_pos >= P2_MIN) && (x_pos <= P2_MAX);
  assign in_spike_s = (x_pos >= SP_MIN) && (x_pos <= SP_MAX);

  assign hazard = floor_s & ((pit1_live_s & in_pit1_s)
                           | (pit2_live_s & in_pit2_s)
                           | (spike_live_s & in_spike_s));

endmodule

// File: rtl/hazard_monitor.sv
// Level-1 death sequencer: debounces the hazard over frame ticks, plays the dying
// animation, then holds a death request until the level re-enters its begin state.
module hazard_monitor
  import level_pkg::*;
#(
  parameter int unsigned PIT1_X_MIN       = PIT1_X_MIN_DEF,
  parameter int unsigned PIT1_X_MAX       = PIT1_X_MAX_DEF,
  parameter int unsigned PIT2_X_MIN       = PIT2_X_MIN_DEF,
  parameter int unsigned PIT2_X_MAX       = PIT2_X_MAX_DEF,
  parameter int unsigned SPIKE_X_MIN      = SPIKE_X_MIN_DEF,
  parameter int unsigned SPIKE_X_MAX      = SPIKE_X_MAX_DEF,
  parameter int unsigned FLOOR_Y          = FLOOR_Y_DEF,
  parameter int unsigned PIT_LETHAL_FRAME = PIT_LETHAL_FRAME_DEF,
  parameter int unsigned CONFIRM_TICKS    = 32'd2,
  parameter int unsigned DYING_TICKS      = 32'd32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       level_1_begin,
  input  logic       init_1,
  input  logic       pit_opening_1,
  input  logic       pit_opened_1,
  input  logic       pit_opening_2,
  input  logic       pit_opened_2,
  input  logic       spikes,
  input  logic       spikes_opened,
  input  logic [6:0] animation_frame_num,
  output logic       death,
  output logic       dying,
  output logic [2:0] death_frame,
  output logic [7:0] death_count
);

  localparam logic [7:0]  CONF_TICKS = 8'(CONFIRM_TICKS);
  localparam logic [15:0] DYING_LAST = 16'(DYING_TICKS - 32'd1);

  hazard_state_t state_r, state_s;
  logic [7:0]    confirm_r, confirm_s;
  logic [15:0]   dtick_r, dtick_s;
  logic [7:0]    count_r, count_s;
  logic          dying_r, death_r;
  logic [2:0]    frame_r;
  logic          hazard_s;
  logic          unused_init_s;

  // init_1 carries no hazard of its own in level 1.
  assign unused_init_s = init_1;

  hazard_decode #(
    .PIT1_X_MIN      (PIT1_X_MIN),
    .PIT1_X_MAX      (PIT1_X_MAX),
    .PIT2_X_MIN      (PIT2_X_MIN),
    .PIT2_X_MAX      (PIT2_X_MAX),
    .SPIKE_X_MIN     (SPIKE_X_MIN),
    .SPIKE_X_MAX     (SPIKE_X_MAX),
    .FLOOR_Y         (FLOOR_Y),
    .PIT_LETHAL_FRAME(PIT_LETHAL_FRAME)
  ) u_decode (
    .x_pos              (x_pos),
    .y_pos              (y_pos),
    .pit_opening_1      (pit_opening_1),
    .pit_opened_1       (pit_opened_1),
    .pit_opening_2      (pit_opening_2),
    .pit_opened_2       (pit_opened_2),
    .spikes             (spikes),
    .spikes_opened      (spikes_opened),
    .animation_frame_num(animation_frame_num),
    .hazard             (hazard_s)
  );

  // Next-state and counter update logic.
  always_comb begin
    state_s   = state_r;
    confirm_s = confirm_r;
    dtick_s   = dtick_r;
    count_s   = count_r;
    case (state_r)
      ALIVE: begin
        if (tick && hazard_s) begin
          if (CONF_TICKS <= 8'd1) begin
            state_s   = DYING;
            confirm_s = 8'd0;
            dtick_s   = 16'd0;
          end else begin
            state_s   = CONFIRM;
            confirm_s = 8'd1;
          end
        end else begin
          confirm_s = 8'd0;
        end
      end
      CONFIRM: begin
        if (tick && hazard_s) begin
          if ((confirm_r + 8'd1) >= CONF_TICKS) begin
            state_s   = DYING;
            confirm_s = 8'd0;
            dtick_s   = 16'd0;
          end else begin
            confirm_s = confirm_r + 8'd1;
          end
        end else if (tick) begin
          state_s   = ALIVE;
          confirm_s = 8'd0;
        end else begin
          state_s = CONFIRM;
        end
      end
      DYING: begin
        if (tick) begin
          if (dtick_r >= DYING_LAST) begin
            state_s = REQUEST;
            dtick_s = 16'd0;
            if (count_r != 8'd255) begin
              count_s = count_r + 8'd1;
            end else begin
              count_s = count_r;
            end
          end else begin
            dtick_s = dtick_r + 16'd1;
          end
        end else begin
          dtick_s = dtick_r;
        end
      end
      REQUEST: begin
        if (level_1_begin) begin
          state_s = ALIVE;
        end else begin
          state_s = REQUEST;
        end
      end
      default: begin
        state_s   = ALIVE;
        confirm_s = 8'd0;
        dtick_s   = 16'd0;
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so they
  // change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ALIVE;
      confirm_r <= 8'd0;
      dtick_r   <= 16'd0;
      count_r   <= 8'd0;
      dying_r   <= 1'b0;
      death_r   <= 1'b0;
      frame_r   <= 3'd0;
    end else begin
      state_r   <= state_s;
      confirm_r <= confirm_s;
      dtick_r   <= dtick_s;
      count_r   <= count_s;
      dying_r   <= (state_s == DYING);
      death_r   <= (state_s == REQUEST);
      frame_r   <= (state_s == DYING) ? dtick_s[4:2] : 3'd0;
    end
  end

  assign death       = death_r;
  assign dying       = dying_r;
  assign death_frame = frame_r;
  assign death_count = count_r;

endmodule

// File: tb/tb_hazard_monitor.sv
// Directed bench for hazard_monitor: a vector table for the hazard decode seen
// through the confirm path, plus hand sequences for the multi-cycle behaviour.
module tb_hazard_monitor;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [7:0] flags;  // {begin, init_1, opening_1, opened_1, opening_2, opened_2, spikes, spikes_opened}
  logic [6:0] frame;
  logic       death;
  logic       dying;
  logic [2:0] death_frame;
  logic [7:0] death_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] flags;
    logic [6:0] frame;
    logic       exp_dying;
  } vec_t;

  vec_t vecs[18];

  hazard_monitor dut (
    .clk                (clk),
    .reset              (reset),
    .tick               (tick),
    .x_pos              (x_pos),
    .y_pos              (y_pos),
    .level_1_begin      (flags[7]),
    .init_1             (flags[6]),
    .pit_opening_1      (flags[5]),
    .pit_opened_1       (flags[4]),
    .pit_opening_2      (flags[3]),
    .pit_opened_2       (flags[2]),
    .spikes             (flags[1]),
    .spikes_opened      (flags[0]),
    .animation_frame_num(frame),
    .death              (death),
    .dying              (dying),
    .death_frame        (death_frame),
    .death_count        (death_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic tick_gap4();
    repeat (3) step(1'b0);
    step(1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1'b0);
    step(1'b0);
    reset = 1'b1;
  endtask

  // Full death: 2 confirm ticks, 32 dying ticks, then acknowledge.
  task automatic run_death();
    x_pos = 10'd210; y_pos = 10'd400; flags = 8'h10; frame = 7'd0;
    repeat (34) step(1'b1);
    flags = 8'h80;
    step(1'b0);
    flags = 8'h00;
  endtask

  initial begin
    vecs[0]  = '{10'd210, 10'd400, 8'h20, 7'd2, 1'b0};
    vecs[1]  = '{10'd210, 10'd400, 8'h20, 7'd3, 1'b1};
    vecs[2]  = '{10'd210, 10'd399, 8'h10, 7'd0, 1'b0};
    vecs[3]  = '{10'd200, 10'd400, 8'h10, 7'd0, 1'b1};
    vecs[4]  = '{10'd239, 10'd400, 8'h10, 7'd0, 1'b1};
    vecs[5]  = '{10'd240, 10'd400, 8'h10, 7'd0, 1'b0};
    vecs[6]  = '{10'd199, 10'd400, 8'h01, 7'd0, 1'b0};
    vecs[7]  = '{10'd365, 10'd400, 8'h04, 7'd0, 1'b1};
    vecs[8]  = '{10'd365, 10'd400, 8'h10, 7'd0, 1'b0};
    vecs[9]  = '{10'd399, 10'd400, 8'h08, 7'd3, 1'b1};
    vecs[10] = '{10'd360, 10'd400, 8'h08, 7'd2, 1'b0};
    vecs[11] = '{10'd500, 10'd400, 8'h02, 7'd0, 1'b0};
    vecs[12] = '{10'd500, 10'd400, 8'h01, 7'd0, 1'b1};
    vecs[13] = '{10'd543, 10'd500, 8'h01, 7'd0, 1'b1};
    vecs[14] = '{10'd544, 10'd400, 8'h01, 7'd0, 1'b0};
    vecs[15] = '{10'd210, 10'd400, 8'h02, 7'd0, 1'b1};
    vecs[16] = '{10'd380, 10'd400, 8'hC0, 7'd9, 1'b0};
    vecs[17] = '{10'd210, 10'd400, 8'h28, 7'd6, 1'b1};

    reset = 1'b0; tick = 1'b0; x_pos = 10'd0; y_pos = 10'd0; flags = 8'h00; frame = 7'd0;
    do_reset();
    check("reset_death", death, 0);
    check("reset_dying", dying, 0);
    check("reset_frame", death_frame, 0);
    check("reset_count", death_count, 0);

    // Decode table, observed through two confirm ticks.
    for (int i = 0; i < 18; i++) begin
      do_reset();
      x_pos = vecs[i].x; y_pos = vecs[i].y; flags = vecs[i].flags; frame = vecs[i].frame;
      step(1'b1);
      check($sformatf("vec%0d_tick1_dying", i), dying, 0);
      step(1'b1);
      check($sformatf("vec%0d_dying", i), dying, vecs[i].exp_dying);
    end

    // Pit 1 opening under the player, one tick every 4 cycles.
    do_reset();
    x_pos = 10'd210; y_pos = 10'd400; flags = 8'h20;
    for (int f = 0; f < 3; f++) begin
      frame = 7'(f);
      tick_gap4();
      check("pit1_early_dying", dying, 0);
    end
    frame = 7'd3;
    tick_gap4();
    check("pit1_confirm_dying", dying, 0);
    step(1'b0);
    check("pit1_confirm_hold", dying, 0);
    frame = 7'd4;
    tick_gap4();
    check("pit1_dying_rise", dying, 1);
    check("pit1_frame0", death_frame, 0);
    frame = 7'd6;
    for (int k = 1; k <= 32; k++) begin
      tick_gap4();
      if (k == 4) check("pit1_frame1", death_frame, 1);
      if (k == 31) begin
        check("pit1_frame7", death_frame, 7);
        check("pit1_dying31", dying, 1);
        check("pit1_death31", death, 0);
      end
      if (k == 32) begin
        check("pit1_death", death, 1);
        check("pit1_dying_fall", dying, 0);
        check("pit1_count", death_count, 1);
        check("pit1_req_frame", death_frame, 0);
      end
    end

    // Acknowledge held off for 10 cycles, then pulsed.
    flags = 8'h00;
    for (int c = 0; c < 10; c++) begin
      step(1'b1);
      check("ack_hold_death", death, 1);
    end
    flags = 8'h80;
    step(1'b0);
    flags = 8'h00;
    check("ack_release", death, 0);
    step(1'b0);
    check("ack_stays_low", death, 0);

    // Brief overlap: one hazard tick, then away; confirm count must restart.
    do_reset();
    x_pos = 10'd365; y_pos = 10'd400; flags = 8'h04;
    step(1'b1);
    x_pos = 10'd300;
    step(1'b1);
    step(1'b1);
    check("overlap_dying", dying, 0);
    x_pos = 10'd365;
    step(1'b1);
    step(1'b0);
    check("overlap_restart", dying, 0);
    step(1'b1);
    check("overlap_second", dying, 1);

    // Spikes only arm with spikes_opened.
    do_reset();
    x_pos = 10'd500; y_pos = 10'd400; flags = 8'h02;
    repeat (5) step(1'b1);
    check("spikes_closed", dying, 0);
    flags = 8'h01;
    step(1'b1);
    check("spikes_open_t1", dying, 0);
    step(1'b1);
    check("spikes_open_t2", dying, 1);

    // Begin already high on entry to REQUEST gives a single-cycle death.
    do_reset();
    x_pos = 10'd210; y_pos = 10'd400; flags = 8'h10;
    repeat (33) step(1'b1);
    flags = 8'h90;
    step(1'b1);
    check("early_ack_death", death, 1);
    flags = 8'h80;
    step(1'b0);
    check("early_ack_fall", death, 0);
    flags = 8'h00;

    // Reset mid-DYING with five deaths on the counter.
    do_reset();
    repeat (5) run_death();
    check("five_deaths", death_count, 5);
    x_pos = 10'd210; y_pos = 10'd400; flags = 8'h10;
    repeat (7) step(1'b1);
    check("mid_dying", dying, 1);
    check("mid_frame", death_frame, 1);
    reset = 1'b0;
    step(1'b1);
    reset = 1'b1;
    flags = 8'h00;
    check("mid_rst_dying", dying, 0);
    check("mid_rst_death", death, 0);
    check("mid_rst_frame", death_frame, 0);
    check("mid_rst_count", death_count, 0);

    // Counter saturation.
    do_reset();
    repeat (255) run_death();
    check("sat_255", death_count, 255);
    run_death();
    check("sat_256", death_count, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
